circle_sequencer: RTL
=====================

# circle_sequencer

Parametrised successor to the fixed five-circle sequencer. Holds a programmable table of up to MAX_ENTRIES circle descriptors (centre, radius, colour, enable) and issues them one at a time to the circle drawer via a start/done handshake. Supports a run-time circle count, skipping disabled entries, loop mode, and button-triggered redraw. Sits between the top-level KEY/config logic and the circle drawer, which owns the VGA adapter.

## Interface
- MAX_ENTRIES, 8, table depth; must be a power of two ≥ 2
- IDX_W, 3, log2(MAX_ENTRIES)
- COORD_W, 8, centre x/y width
- RAD_W, 8, radius width
- AUTO_START, 1, 1 = start one run automatically in the first cycle after reset release

- CLOCK_50  in  1  sole clock; all logic on its rising edge
- KEY  in  4  KEY[3] = reset, synchronous, active-low; KEY[0] = active-low redraw button; KEY[2:1] unused
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDX_W  table entry to write
- cfg_x, cfg_y  in  COORD_W  centre written to the entry
- cfg_r  in  RAD_W  radius written to the entry
- cfg_colour  in  3  colour written to the entry
- cfg_en  in  1  entry enable written to the entry
- num_circles  in  IDX_W+1  entries per run; sampled at start; clamped to MAX_ENTRIES
- loop_en  in  1  1 = wrap to entry 0 after the last entry; sampled each time the last entry completes
- draw_done  in  1  one-cycle completion pulse from the drawer
- draw_start  out  1  one-cycle request to the drawer
- draw_x, draw_y  out  COORD_W  registered centre; stable from draw_start until draw_done
- draw_r  out  RAD_W  registered radius
- draw_colour  out  3  registered colour
- busy  out  1  high in LOAD/ISSUE/WAIT/NEXT
- seq_done  out  1  high in DONE
- cur_idx  out  IDX_W  entry currently loaded or drawn

## Operation
- Reset (KEY[3] low at an edge):
  - state = IDLE; all outputs 0.
  - Table reloads defaults, radius 20: entry 0 (36,40,BLUE=001), entry 1 (124,40,RED=100), entry 2 (80,40,WHITE=111), entry 3 (58,80,YELLOW=110), entry 4 (102,80,GREEN=010); entries 5+ disabled and zero.
  - N register resets to 5.
- Start request:
  - KEY[0] passes through a 2-flop synchroniser; a falling edge of the synchronised value is a request.
  - AUTO_START gives one request in the first post-reset cycle.
  - Accepted only in IDLE or DONE; dropped (not queued) otherwise.
- States:
  - IDLE/DONE + request: N = min(num_circles, MAX_ENTRIES), idx = 0. Go to LOAD, or straight to DONE when N = 0.
  - LOAD: read entry idx. If enabled, register it onto draw_* and go to ISSUE. If disabled, go to NEXT with draw_* unchanged.
  - ISSUE: draw_start = 1 for this cycle only; go to WAIT.
  - WAIT: hold until draw_done = 1, then go to NEXT. draw_done in any other state is ignored.
  - NEXT: if idx+1 < N, idx++ and go to LOAD. Otherwise, if loop_en, idx = 0 and go to LOAD; else go to DONE.
  - DONE: draw_* hold the last values; leave only on a request.
- Table writes are accepted in every state.
  - A write in the same cycle as a LOAD read of the same entry: LOAD gets the old value; the new value applies from the next cycle.
  - Writes never alter draw_* mid-draw.
- Reset mid-draw aborts with no further draw_start. The drawer shares KEY[3] and must abort too.

## Timing
- Request accepted at edge t: LOAD in cycle t+1; draw_start high in cycle t+2.
- draw_done sampled at edge k: NEXT in cycle k+1; next draw_start in cycle k+3 if the next entry is enabled.
- Each disabled entry adds 2 cycles (LOAD, NEXT).
- KEY[0] press to request: 3 cycles.
- draw_* change only on the LOAD→ISSUE edge.
- seq_done rises the cycle after the final NEXT and falls the cycle after a request is accepted.

## Test plan
- Reset, AUTO_START=1, drawer model answers draw_done 10 cycles after each draw_start → five draw_starts with (36,40,20,001), (124,40,20,100), (80,40,20,111), (58,80,20,110), (102,80,20,010) in order. seq_done rises, busy falls, no sixth draw_start.
- Write entry 2 with cfg_en = 0, set num_circles = 5, pulse KEY[0] → four draws (entries 0,1,3,4). Gap between entry 1's draw_done and entry 3's draw_start is 5 cycles.
- num_circles = 0 with a request → seq_done the next cycle, no draw_start. num_circles = 15 → clamped to 8; entries 5–7 are skipped while disabled.
- loop_en = 1, N = 2 → draw order 0,1,0,1,… with busy held. Drop loop_en during entry 1 → DONE after entry 1 completes.
- Press KEY[0] and issue draw_done pulses while in LOAD/ISSUE → the request is ignored and no spurious state advance occurs. Write the entry being drawn during WAIT → draw_* unchanged.
- Assert KEY[3] in WAIT of entry 3 → next cycle: all outputs 0, defaults restored, then a fresh auto-run from entry 0.

Source files
------------

// File: rtl/circle_sequencer_if.sv
// Drawer-side bus of the circle sequencer: one request/completion handshake plus the circle
// descriptor that travels with it.
// draw_start pulses for one cycle with draw_x/y/r/colour valid; those hold unchanged until the
// drawer answers with a one-cycle draw_done pulse. No new draw_start is issued before draw_done.
interface circle_sequencer_if #(
  parameter int COORD_W = 8,
  parameter int RAD_W   = 8
);
  logic               draw_start;
  logic               draw_done;
  logic [COORD_W-1:0] draw_x;
  logic [COORD_W-1:0] draw_y;
  logic [RAD_W-1:0]   draw_r;
  logic [2:0]         draw_colour;

  modport master (output draw_start, draw_x, draw_y, draw_r, draw_colour, input draw_done);
  modport slave  (input draw_start, draw_x, draw_y, draw_r, draw_colour, output draw_done);
endinterface

// File: rtl/circle_sequencer.sv
// Programmable circle table sequencer: walks up to MAX_ENTRIES descriptors, skipping disabled
// ones, and hands each enabled circle to the drawer over circle_sequencer_if.
module circle_sequencer #(
  parameter int MAX_ENTRIES = 8,
  parameter int IDX_W       = 3,
  parameter int COORD_W     = 8,
  parameter int RAD_W       = 8,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic               CLOCK_50,
  input  logic [3:0]         KEY,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [RAD_W-1:0]   cfg_r,
  input  logic [2:0]         cfg_colour,
  input  logic               cfg_en,
  input  logic [IDX_W:0]     num_circles,
  input  logic               loop_en,
  circle_sequencer_if.master dbus,
  output logic               busy,
  output logic               seq_done,
  output logic [IDX_W-1:0]   cur_idx,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic               en;
    logic [2:0]         colour;
    logic [RAD_W-1:0]   r;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } entry_t;

  // Power-on picture: five radius-20 circles, remaining entries disabled.
  function automatic entry_t default_entry(input int i);
    entry_t e;
    e = '0;
    case (i)
      0: e = '{en: 1'b1, colour: 3'b001, r: RAD_W'(20), y: COORD_W'(40), x: COORD_W'(36)};
      1: e = '{en: 1'b1, colour: 3'b100, r: RAD_W'(20), y: COORD_W'(40), x: COORD_W'(124)};
      2: e = '{en: 1'b1, colour: 3'b111, r: RAD_W'(20), y: COORD_W'(40), x: COORD_W'(80)};
      3: e = '{en: 1'b1, colour: 3'b110, r: RAD_W'(20), y: COORD_W'(80), x: COORD_W'(58)};
      4: e = '{en: 1'b1, colour: 3'b010, r: RAD_W'(20), y: COORD_W'(80), x: COORD_W'(102)};
      default: e = '0;
    endcase
    return e;
  endfunction

  logic   rst_n;
  logic   unused_keys;
  logic   [2:0] key0_sync;
  logic   auto_pend;
  logic   req;
  state_t state_q, state_d;
  logic   [IDX_W-1:0] idx_q, idx_d;
  logic   [IDX_W:0]   n_q, n_d, n_clamped;
  logic   load_draw;
  entry_t rd;
  entry_t table_q [MAX_ENTRIES];

  assign rst_n       = KEY[3];
  assign unused_keys = &{1'b0, KEY[2:1]};

  // key0_sync[1:0] is the synchroniser, key0_sync[2] the previous synchronised value.
  assign req = auto_pend | (key0_sync[2] & ~key0_sync[1]);
  assign n_clamped = (num_circles > (IDX_W+1)'(MAX_ENTRIES)) ? (IDX_W+1)'(MAX_ENTRIES)
                                                            : num_circles;
  assign rd = table_q[idx_q];

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      key0_sync <= 3'b111;
      auto_pend <= AUTO_START;
    end else begin
      key0_sync <= {key0_sync[1:0], KEY[0]};
      auto_pend <= 1'b0;
    end
  end

  // A write colliding with a LOAD read lands after the read, so LOAD sees the old entry.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_ENTRIES; i++) table_q[i] <= default_entry(i);
    end else if (cfg_we) begin
      table_q[cfg_addr] <= '{en: cfg_en, colour: cfg_colour, r: cfg_r, y: cfg_y, x: cfg_x};
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    load_draw = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          n_d     = n_clamped;
          idx_d   = '0;
          state_d = (n_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (rd.en) begin
          load_draw = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (dbus.draw_done) state_d = S_NEXT;
      S_NEXT: begin
        if (({1'b0, idx_q} + (IDX_W+1)'(1)) < n_q) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD;
        end else if (loop_en) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      n_q              <= (IDX_W+1)'(5);
      dbus.draw_x      <= '0;
      dbus.draw_y      <= '0;
      dbus.draw_r      <= '0;
      dbus.draw_colour <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      if (load_draw) begin
        dbus.draw_x      <= rd.x;
        dbus.draw_y      <= rd.y;
        dbus.draw_r      <= rd.r;
        dbus.draw_colour <= rd.colour;
      end
    end
  end

  assign dbus.draw_start = (state_q == S_ISSUE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                     (state_q == S_WAIT) || (state_q == S_NEXT);
  assign seq_done  = (state_q == S_DONE);
  assign cur_idx   = idx_q;
  assign state_dbg = state_q;

endmodule
